// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-protocol types plus the arbiter's own state and grant encodings.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Progress reported by the single-port RAM model.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  // Which requester completed most recently; the other one wins the next tie.
  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the arbiter's requester-side and RAM-side signals, in the same style
// as the control-unit interface, with views for the arbiter and the bench.
interface mem_arbiter_if import cpu_types_pkg::*; #(
  parameter int CNT_W = 32
);
  logic             CLK;
  logic             RST;
  logic             iREN;
  word_t            iaddr;
  word_t            iload;
  logic             ihit;
  logic             dREN;
  logic             dWEN;
  word_t            daddr;
  word_t            dstore;
  word_t            dload;
  logic             dhit;
  logic             halt;
  logic             ramREN;
  logic             ramWEN;
  word_t            ramaddr;
  word_t            ramstore;
  word_t            ramload;
  ramstate_t        ramstate;
  logic             err;
  logic [CNT_W-1:0] icount;
  logic [CNT_W-1:0] dcount;

  modport arb (
    input  CLK, RST, iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramstate,
    output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err, icount, dcount
  );

  modport tb (
    output CLK, RST, iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramstate,
    input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err, icount, dcount
  );

endinterface

// File: rtl/arb_wait_timer.sv
// Counts cycles spent in a grant; tc flags the last cycle allowed before the
// grant is declared failed.
module arb_wait_timer #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [W-1:0] cnt;

  // Clear dominates so every grant starts counting from zero.
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single-port RAM with alternating
// tie-break, abort on withdrawal, halt gating, timeout/error flag and counters.
//
// state | meaning
// IDLE  | no grant; picks the next requester unless halt is high
// IGNT  | instruction fetch owns the RAM until ACCESS, abort, error or timeout
// DGNT  | data load/store owns the RAM until ACCESS, abort, error or timeout
module mem_arbiter import cpu_types_pkg::*; #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             iREN,
  input  word_t            iaddr,
  output word_t            iload,
  output logic             ihit,
  input  logic             dREN,
  input  logic             dWEN,
  input  word_t            daddr,
  input  word_t            dstore,
  output word_t            dload,
  output logic             dhit,
  input  logic             halt,
  output logic             ramREN,
  output logic             ramWEN,
  output word_t            ramaddr,
  output word_t            ramstore,
  input  word_t            ramload,
  input  ramstate_t        ramstate,
  output logic             err,
  output logic [CNT_W-1:0] icount,
  output logic [CNT_W-1:0] dcount
);

  arb_state_t state, nxt;
  grant_t     last_grant;
  logic       dreq;
  logic       set_err;
  logic       tc;
  logic       timer_clr;

  assign dreq      = dREN | dWEN;
  assign timer_clr = (state == IDLE) || (nxt == IDLE);

  arb_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
    .CLK (CLK),
    .RST (RST),
    .clr (timer_clr),
    .en  (state != IDLE),
    .tc  (tc)
  );

  // Next-state selection and RAM/hit drive from the state and the live requests.
  always_comb begin
    nxt      = state;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;
    set_err  = 1'b0;
    case (state)
      IDLE: begin
        if (!halt) begin
          if (dreq && iREN) begin
            nxt = (last_grant == GNT_I) ? DGNT : IGNT;
          end else if (dreq) begin
            nxt = DGNT;
          end else if (iREN) begin
            nxt = IGNT;
          end
        end
      end
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          nxt = IDLE;
        end else if (ramstate == ERROR) begin
          set_err = 1'b1;
          nxt     = IDLE;
        end else if (ramstate == ACCESS) begin
          ihit = 1'b1;
          nxt  = IDLE;
        end else if (tc) begin
          set_err = 1'b1;
          nxt     = IDLE;
        end
      end
      DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dreq) begin
          nxt = IDLE;
        end else if (ramstate == ERROR) begin
          set_err = 1'b1;
          nxt     = IDLE;
        end else if (ramstate == ACCESS) begin
          dhit = 1'b1;
          nxt  = IDLE;
        end else if (tc) begin
          set_err = 1'b1;
          nxt     = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
    // Reset takes the RAM away immediately, even mid-grant.
    if (RST) begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      ihit     = 1'b0;
      dhit     = 1'b0;
      set_err  = 1'b0;
    end
  end

  // Read data is only presented on a hit; a store hit returns zero.
  always_comb begin
    iload = ihit ? ramload : '0;
    dload = (dhit && !dWEN) ? ramload : '0;
  end

  // State register, tie-break memory, sticky error and completion counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      last_grant <= GNT_I;
      err        <= 1'b0;
      icount     <= '0;
      dcount     <= '0;
    end else begin
      state <= nxt;
      if (set_err) begin
        err <= 1'b1;
      end
      if (ihit) begin
        icount     <= icount + CNT_W'(1);
        last_grant <= GNT_I;
      end
      if (dhit) begin
        dcount     <= dcount + CNT_W'(1);
        last_grant <= GNT_D;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table for the basic fetch,
// store and load flows, then hand-written sequences for the multi-cycle corners.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  mem_arbiter_if #(.CNT_W(32)) mif ();

  mem_arbiter #(.TIMEOUT_CYC(64), .CNT_W(32)) dut (
    .CLK      (mif.CLK),
    .RST      (mif.RST),
    .iREN     (mif.iREN),
    .iaddr    (mif.iaddr),
    .iload    (mif.iload),
    .ihit     (mif.ihit),
    .dREN     (mif.dREN),
    .dWEN     (mif.dWEN),
    .daddr    (mif.daddr),
    .dstore   (mif.dstore),
    .dload    (mif.dload),
    .dhit     (mif.dhit),
    .halt     (mif.halt),
    .ramREN   (mif.ramREN),
    .ramWEN   (mif.ramWEN),
    .ramaddr  (mif.ramaddr),
    .ramstore (mif.ramstore),
    .ramload  (mif.ramload),
    .ramstate (mif.ramstate),
    .err      (mif.err),
    .icount   (mif.icount),
    .dcount   (mif.dcount)
  );

  int   checks = 0;
  int   errors = 0;
  logic seen_ihit = 1'b0;
  logic seen_dhit = 1'b0;

  typedef struct {
    logic      iren, dren, dwen;
    ramstate_t rs;
    word_t     iaddr, daddr, dstore, rload;
    logic      e_ren, e_wen;
    word_t     e_addr, e_store;
    logic      e_ihit, e_dhit;
    word_t     e_iload, e_dload;
  } vec_t;

  vec_t vt[9];

  initial mif.CLK = 1'b0;
  always #5 mif.CLK = ~mif.CLK;

  // The two RAM enables must never be high together.
  always @(negedge mif.CLK) begin
    checks++;
    if (mif.ramREN && mif.ramWEN) begin
      errors++;
      $display("FAIL ren_wen_exclusive: ramREN=%b ramWEN=%b required not both 1", mif.ramREN, mif.ramWEN);
    end
    if (mif.ihit) seen_ihit = 1'b1;
    if (mif.dhit) seen_dhit = 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge mif.CLK);
    #1;
  endtask

  task automatic idle_inputs();
    mif.iREN     = 1'b0;
    mif.dREN     = 1'b0;
    mif.dWEN     = 1'b0;
    mif.halt     = 1'b0;
    mif.iaddr    = '0;
    mif.daddr    = '0;
    mif.dstore   = '0;
    mif.ramload  = '0;
    mif.ramstate = FREE;
  endtask

  task automatic do_reset();
    idle_inputs();
    mif.RST = 1'b1;
    step();
    step();
    mif.RST = 1'b0;
  endtask

  function automatic vec_t mk(input logic iren, dren, dwen, input ramstate_t rs,
                              input word_t iaddr, daddr, dstore, rload,
                              input logic e_ren, e_wen, input word_t e_addr, e_store,
                              input logic e_ihit, e_dhit, input word_t e_iload, e_dload);
    vec_t v;
    v.iren = iren; v.dren = dren; v.dwen = dwen; v.rs = rs;
    v.iaddr = iaddr; v.daddr = daddr; v.dstore = dstore; v.rload = rload;
    v.e_ren = e_ren; v.e_wen = e_wen; v.e_addr = e_addr; v.e_store = e_store;
    v.e_ihit = e_ihit; v.e_dhit = e_dhit; v.e_iload = e_iload; v.e_dload = e_dload;
    return v;
  endfunction

  // Simultaneous fetch and load; exp_d_first says which one must be served first.
  task automatic tie(input logic exp_d_first, input string nm);
    mif.iREN = 1'b1; mif.dREN = 1'b1; mif.dWEN = 1'b0;
    mif.iaddr = 32'h0000_0080; mif.daddr = 32'h0000_0300;
    mif.ramstate = FREE;
    step();
    mif.ramstate = ACCESS; mif.ramload = 32'h1111_2222;
    #1;
    chk({nm, "_first_dhit"}, 32'(mif.dhit), 32'(exp_d_first));
    chk({nm, "_first_ihit"}, 32'(mif.ihit), 32'(!exp_d_first));
    step();
    if (exp_d_first) mif.dREN = 1'b0;
    else             mif.iREN = 1'b0;
    mif.ramstate = FREE;
    step();
    mif.ramstate = ACCESS;
    #1;
    chk({nm, "_second_ihit"}, 32'(mif.ihit), 32'(exp_d_first));
    chk({nm, "_second_dhit"}, 32'(mif.dhit), 32'(!exp_d_first));
    step();
    mif.iREN = 1'b0; mif.dREN = 1'b0; mif.ramstate = FREE;
    step();
  endtask

  initial begin
    mif.RST = 1'b1;
    idle_inputs();

    //      iren dren dwen rs      iaddr          daddr          dstore         rload          ren  wen  addr           store          ihit dhit iload          dload
    vt[0] = mk(1, 0, 0, FREE,   32'h0000_0040, 32'h0,         32'h0,         32'h0,         0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0);
    vt[1] = mk(1, 0, 0, BUSY,   32'h0000_0040, 32'h0,         32'h0,         32'h0,         1, 0, 32'h0000_0040, 32'h0,         0, 0, 32'h0,         32'h0);
    vt[2] = mk(1, 0, 0, BUSY,   32'h0000_0040, 32'h0,         32'h0,         32'h0,         1, 0, 32'h0000_0040, 32'h0,         0, 0, 32'h0,         32'h0);
    vt[3] = mk(1, 0, 0, ACCESS, 32'h0000_0040, 32'h0,         32'h0,         32'h2402_0005, 1, 0, 32'h0000_0040, 32'h0,         1, 0, 32'h2402_0005, 32'h0);
    vt[4] = mk(0, 0, 1, FREE,   32'h0,         32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0);
    vt[5] = mk(0, 0, 1, BUSY,   32'h0,         32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'h0,         32'h0);
    vt[6] = mk(0, 0, 1, ACCESS, 32'h0,         32'h0000_0100, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1, 32'h0,         32'h0);
    vt[7] = mk(0, 1, 0, FREE,   32'h0,         32'h0000_0200, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0);
    vt[8] = mk(0, 1, 0, ACCESS, 32'h0,         32'h0000_0200, 32'h0,         32'hCAFE_F00D, 1, 0, 32'h0000_0200, 32'h0,         0, 1, 32'h0,         32'hCAFE_F00D);

    // Reset state, with a request already present.
    step();
    mif.iREN = 1'b1;
    #1;
    chk("rst_ramREN", 32'(mif.ramREN), 32'h0);
    chk("rst_ihit",   32'(mif.ihit),   32'h0);
    chk("rst_err",    32'(mif.err),    32'h0);
    chk("rst_icount", mif.icount,      32'h0);
    chk("rst_dcount", mif.dcount,      32'h0);
    do_reset();

    // Vector table: fetch with two BUSY cycles, then a store, then a load.
    for (int i = 0; i < 9; i++) begin
      mif.iREN = vt[i].iren; mif.dREN = vt[i].dren; mif.dWEN = vt[i].dwen;
      mif.ramstate = vt[i].rs; mif.iaddr = vt[i].iaddr; mif.daddr = vt[i].daddr;
      mif.dstore = vt[i].dstore; mif.ramload = vt[i].rload;
      #1;
      chk($sformatf("vec%0d_ramREN", i),   32'(mif.ramREN), 32'(vt[i].e_ren));
      chk($sformatf("vec%0d_ramWEN", i),   32'(mif.ramWEN), 32'(vt[i].e_wen));
      chk($sformatf("vec%0d_ramaddr", i),  mif.ramaddr,     vt[i].e_addr);
      chk($sformatf("vec%0d_ramstore", i), mif.ramstore,    vt[i].e_store);
      chk($sformatf("vec%0d_ihit", i),     32'(mif.ihit),   32'(vt[i].e_ihit));
      chk($sformatf("vec%0d_dhit", i),     32'(mif.dhit),   32'(vt[i].e_dhit));
      chk($sformatf("vec%0d_iload", i),    mif.iload,       vt[i].e_iload);
      chk($sformatf("vec%0d_dload", i),    mif.dload,       vt[i].e_dload);
      step();
    end
    idle_inputs();
    chk("table_icount", mif.icount,      32'd1);
    chk("table_dcount", mif.dcount,      32'd2);
    chk("table_err",    32'(mif.err),    32'h0);

    // Tie alternation: fresh reset means data first, and each tie serves both.
    do_reset();
    tie(1'b1, "tie1");
    tie(1'b1, "tie2");
    tie(1'b1, "tie3");
    tie(1'b1, "tie4");
    // After a lone data access the next tie must go to the fetch.
    mif.dWEN = 1'b1; mif.daddr = 32'h0000_0400; mif.dstore = 32'h0000_00AA;
    step();
    mif.ramstate = ACCESS;
    #1;
    chk("lone_store_dhit", 32'(mif.dhit), 32'h1);
    step();
    idle_inputs();
    step();
    tie(1'b0, "tie5");
    tie(1'b0, "tie6");
    chk("tie_icount", mif.icount, 32'd6);
    chk("tie_dcount", mif.dcount, 32'd7);

    // Abort: load withdrawn while BUSY.
    do_reset();
    seen_dhit = 1'b0;
    mif.dREN = 1'b1; mif.daddr = 32'h0000_0500;
    step();
    mif.ramstate = BUSY;
    #1;
    chk("abort_granted_ramREN", 32'(mif.ramREN), 32'h1);
    step();
    mif.dREN = 1'b0;
    #1;
    chk("abort_drop_ramREN", 32'(mif.ramREN), 32'h0);
    step();
    mif.ramstate = ACCESS;
    mif.dREN = 1'b1;
    #1;
    chk("abort_back_idle_ramREN", 32'(mif.ramREN), 32'h0);
    chk("abort_no_dhit_now", 32'(mif.dhit), 32'h0);
    mif.dREN = 1'b0;
    step();
    chk("abort_seen_dhit", 32'(seen_dhit), 32'h0);
    chk("abort_dcount", mif.dcount, 32'h0);
    chk("abort_err", 32'(mif.err), 32'h0);
    tie(1'b1, "tie_after_abort");

    // Timeout: RAM stays BUSY for the whole allowed window.
    do_reset();
    seen_ihit = 1'b0;
    mif.iREN = 1'b1; mif.iaddr = 32'h0000_0600;
    step();
    mif.ramstate = BUSY;
    for (int k = 0; k < 63; k++) step();
    #1;
    chk("to_cycle64_ramREN", 32'(mif.ramREN), 32'h1);
    chk("to_cycle64_err",    32'(mif.err),    32'h0);
    step();
    chk("to_err_set",     32'(mif.err),    32'h1);
    chk("to_idle_ramREN", 32'(mif.ramREN), 32'h0);
    mif.iREN = 1'b0;
    step(); step(); step();
    chk("to_err_sticky", 32'(mif.err),   32'h1);
    chk("to_seen_ihit",  32'(seen_ihit), 32'h0);
    chk("to_icount",     mif.icount,     32'h0);
    do_reset();
    chk("to_err_cleared", 32'(mif.err), 32'h0);

    // ERROR from the RAM during a data grant.
    mif.dREN = 1'b1; mif.daddr = 32'h0000_0700;
    step();
    mif.ramstate = ERROR;
    #1;
    chk("rerr_no_dhit", 32'(mif.dhit), 32'h0);
    step();
    mif.ramstate = FREE;
    #1;
    chk("rerr_err_set",     32'(mif.err),    32'h1);
    chk("rerr_idle_ramREN", 32'(mif.ramREN), 32'h0);
    mif.dREN = 1'b0;
    step();
    chk("rerr_dcount", mif.dcount, 32'h0);

    // halt blocks grants from IDLE but not an access already granted.
    do_reset();
    mif.halt = 1'b1; mif.iREN = 1'b1; mif.iaddr = 32'h0000_0800;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("halt_idle%0d_ramREN", k), 32'(mif.ramREN), 32'h0);
      step();
    end
    mif.halt = 1'b0;
    step();
    mif.ramstate = ACCESS; mif.ramload = 32'h0000_0808;
    #1;
    chk("halt_release_ihit", 32'(mif.ihit), 32'h1);
    step();
    mif.iREN = 1'b0; mif.ramstate = FREE;
    mif.dREN = 1'b1; mif.daddr = 32'h0000_0900;
    step();
    mif.halt = 1'b1; mif.ramstate = BUSY;
    step();
    mif.ramstate = ACCESS; mif.ramload = 32'h0000_0909;
    #1;
    chk("halt_inflight_dhit",  32'(mif.dhit), 32'h1);
    chk("halt_inflight_dload", mif.dload,     32'h0000_0909);
    step();
    mif.ramstate = FREE; mif.iREN = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("halt_after%0d_ramREN", k), 32'(mif.ramREN), 32'h0);
      step();
    end
    chk("halt_icount", mif.icount, 32'd1);
    chk("halt_dcount", mif.dcount, 32'd1);
    idle_inputs();

    // Reset asserted during a grant with ACCESS present.
    do_reset();
    mif.iREN = 1'b1; mif.iaddr = 32'h0000_0A00;
    step();
    mif.ramstate = ACCESS; mif.ramload = 32'h0000_0A0A; mif.RST = 1'b1;
    #1;
    chk("rstmid_ramREN", 32'(mif.ramREN), 32'h0);
    chk("rstmid_ihit",   32'(mif.ihit),   32'h0);
    chk("rstmid_iload",  mif.iload,       32'h0);
    step();
    mif.RST = 1'b0;
    #1;
    chk("rstmid_idle_ramREN", 32'(mif.ramREN), 32'h0);
    chk("rstmid_icount",      mif.icount,      32'h0);
    idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
